// File: rtl/lab5_rr_arbiter.sv
// lab5_rr_arbiter: 8-way round-robin arbiter with grant holding.
// Optional hold limit with forced revoke when ARB_HOLD_LIMIT_EN is defined.
module lab5_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_grant;
    logic [2:0] r_idx;
    logic       r_valid;

    logic [2:0] w_win;
    logic       w_found;
    logic [2:0] w_next_ptr;
    logic       w_held;

    // Scan from ptr upward, wrapping, so bit position alone never wins.
    always_comb begin
        logic [2:0] w_cand;
        w_win   = 3'd0;
        w_found = 1'b0;
        w_cand  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_cand = r_ptr + 3'(i);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_next_ptr = r_idx + 3'd1;
    assign w_held     = req[r_idx];

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= 3'd0;
            r_grant   <= 8'd0;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= 8'd1 << w_win;
                        r_idx   <= w_win;
                        r_valid <= 1'b1;
                        r_cnt   <= CW'(1);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_held) begin
                        r_grant <= 8'd0;
                        r_valid <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end else if (r_cnt == CW'(MAX_HOLD)) begin
                        // Still requesting at the limit: revoke and demote.
                        r_grant   <= 8'd0;
                        r_valid   <= 1'b0;
                        r_ptr     <= w_next_ptr;
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign timeout = r_timeout;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_grant <= 8'd0;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= 8'd1 << w_win;
                        r_idx   <= w_win;
                        r_valid <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_held) begin
                        r_grant <= 8'd0;
                        r_valid <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign timeout = 1'b0;
`endif

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = r_valid;

endmodule
